// File: rtl/count_monitor.sv
// Cycle-by-cycle checker for the up-counter: step legality, limit, wrap and stall, with sticky alarms.
// Define COUNT_MONITOR_ASSERT_EN to compile immediate assertions for formal/BMC.
module count_monitor #(
    parameter int WIDTH     = 10,
    parameter int LIMIT     = 1000,
    parameter int STALL_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [WIDTH-1:0] count,
    input  logic             clear,
    output logic             alarm_step,
    output logic             alarm_limit,
    output logic             alarm_stall,
    output logic             wrap_pulse,
    output logic [WIDTH-1:0] max_seen,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRIP = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
    localparam logic [7:0]       STALL_V = 8'(STALL_MAX);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             inc_prev_q, inc_prev_d;
    logic [7:0]       stall_q, stall_d;
    logic             alarm_step_q, alarm_step_d;
    logic             alarm_limit_q, alarm_limit_d;
    logic             alarm_stall_q, alarm_stall_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] delta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            prev_q        <= '0;
            inc_prev_q    <= 1'b0;
            stall_q       <= '0;
            alarm_step_q  <= 1'b0;
            alarm_limit_q <= 1'b0;
            alarm_stall_q <= 1'b0;
            wrap_q        <= 1'b0;
            max_q         <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            inc_prev_q    <= inc_prev_d;
            stall_q       <= stall_d;
            alarm_step_q  <= alarm_step_d;
            alarm_limit_q <= alarm_limit_d;
            alarm_stall_q <= alarm_stall_d;
            wrap_q        <= wrap_d;
            max_q         <= max_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = count;
        inc_prev_d    = inc;
        stall_d       = stall_q;
        alarm_step_d  = alarm_step_q;
        alarm_limit_d = alarm_limit_q;
        alarm_stall_d = alarm_stall_q;
        wrap_d        = 1'b0;
        max_d         = max_q;
        // The counter applies inc one cycle late, so the expected step is last cycle's inc.
        delta         = count - prev_q;

        if (clear) begin
            state_d       = ST_INIT;
            stall_d       = '0;
            alarm_step_d  = 1'b0;
            alarm_limit_d = 1'b0;
            alarm_stall_d = 1'b0;
            max_d         = '0;
        end else begin
            if (count > max_q) begin
                max_d = count;
            end
            case (state_q)
                ST_INIT: state_d = ST_RUN;
                ST_RUN, ST_TRIP: begin
                    if (state_q == ST_RUN && delta != {{(WIDTH-1){1'b0}}, inc_prev_q}) begin
                        alarm_step_d = 1'b1;
                        state_d      = ST_TRIP;
                    end
                    wrap_d = (delta == WIDTH'(1)) && (count == '0);
                    if (count >= LIMIT_V) begin
                        alarm_limit_d = 1'b1;
                    end
                    if (inc) begin
                        stall_d = '0;
                    end else if (stall_q < STALL_V) begin
                        stall_d = stall_q + 8'd1;
                    end
                    if (stall_d == STALL_V) begin
                        alarm_stall_d = 1'b1;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    assign alarm_step  = alarm_step_q;
    assign alarm_limit = alarm_limit_q;
    assign alarm_stall = alarm_stall_q;
    assign wrap_pulse  = wrap_q;
    assign max_seen    = max_q;
    assign state       = state_q;

`ifdef COUNT_MONITOR_ASSERT_EN
    logic initstate_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            initstate_q <= 1'b1;
        end else begin
            initstate_q <= 1'b0;
        end
    end

    always_comb begin
        if (!initstate_q) begin
            assert (!alarm_step_q);
            if (state_q == ST_RUN) begin
                assert (max_q >= prev_q);
            end
            if (wrap_q) begin
                assert (state_q != ST_INIT);
            end
        end
    end
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: vector table, directed corner sequences and
// randomized stimulus against a history-based reference model.
module tb_count_monitor;

    localparam int W    = 10;
    localparam int LIM  = 1000;
    localparam int SMAX = 16;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inc_v = 1'b0;
    logic [W-1:0] count_v = '0;
    logic         clear_v = 1'b0;
    logic         alarm_step, alarm_limit, alarm_stall, wrap_pulse;
    logic [W-1:0] max_seen;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;

    // samples accepted since the last reset or clear; index 0 is the capture cycle
    int hc[$];
    bit hi[$];

    count_monitor #(.WIDTH(W), .LIMIT(LIM), .STALL_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n), .inc(inc_v), .count(count_v), .clear(clear_v),
        .alarm_step(alarm_step), .alarm_limit(alarm_limit), .alarm_stall(alarm_stall),
        .wrap_pulse(wrap_pulse), .max_seen(max_seen), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit       inc;
        int       count;
        bit       clr;
        bit       e_step;
        bit       e_limit;
        bit       e_stall;
        bit       e_wrap;
        int       e_max;
        int       e_state;
    } vec_t;

    vec_t vecs[11];

    function automatic int step_of(int a, int b);
        return (a - b) & MASK;
    endfunction

    function automatic bit m_step();
        for (int i = 1; i < hc.size(); i++)
            if (step_of(hc[i], hc[i-1]) != int'(hi[i-1])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_limit();
        for (int i = 1; i < hc.size(); i++)
            if (hc[i] >= LIM) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        int run = 0;
        for (int i = 1; i < hc.size(); i++) begin
            run = hi[i] ? 0 : run + 1;
            if (run >= SMAX) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_wrap();
        int n = hc.size();
        if (n < 2) return 1'b0;
        return (hc[n-1] == 0) && (step_of(hc[n-1], hc[n-2]) == 1);
    endfunction

    function automatic int m_max();
        int m = 0;
        foreach (hc[i]) if (hc[i] > m) m = hc[i];
        return m;
    endfunction

    function automatic int m_state();
        if (hc.size() == 0) return 0;
        return m_step() ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".alarm_step"}, int'(alarm_step), int'(m_step()));
        chk({tag, ".alarm_limit"}, int'(alarm_limit), int'(m_limit()));
        chk({tag, ".alarm_stall"}, int'(alarm_stall), int'(m_stall()));
        chk({tag, ".wrap_pulse"}, int'(wrap_pulse), int'(m_wrap()));
        chk({tag, ".max_seen"}, int'(max_seen), m_max());
        chk({tag, ".state"}, int'(state), m_state());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".alarm_step"}, int'(alarm_step), 0);
        chk({tag, ".alarm_limit"}, int'(alarm_limit), 0);
        chk({tag, ".alarm_stall"}, int'(alarm_stall), 0);
        chk({tag, ".wrap_pulse"}, int'(wrap_pulse), 0);
        chk({tag, ".max_seen"}, int'(max_seen), 0);
        chk({tag, ".state"}, int'(state), 0);
    endtask

    // one clock edge: the model consumes exactly what the DUT sampled
    task automatic tick();
        @(posedge clk);
        if (clear_v) begin
            hc.delete();
            hi.delete();
        end else begin
            hc.push_back(int'(count_v));
            hi.push_back(inc_v);
        end
        #1;
    endtask

    // counter-following cycle: count advances by this cycle's inc on the next edge
    task automatic ctr(input bit i);
        inc_v = i;
        tick();
        count_v = count_v + W'(i);
    endtask

    task automatic do_reset(input int start);
        rst_n = 1'b0;
        inc_v = 1'b0;
        clear_v = 1'b0;
        hc.delete();
        hi.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        count_v = W'(start);
    endtask

    initial begin
        int p;

        vecs[0]  = '{1, 5,  0, 0, 0, 0, 0, 5,  1};
        vecs[1]  = '{1, 6,  0, 0, 0, 0, 0, 6,  1};
        vecs[2]  = '{1, 7,  0, 0, 0, 0, 0, 7,  1};
        vecs[3]  = '{1, 8,  0, 0, 0, 0, 0, 8,  1};
        vecs[4]  = '{1, 9,  0, 0, 0, 0, 0, 9,  1};
        vecs[5]  = '{0, 10, 0, 0, 0, 0, 0, 10, 1};
        vecs[6]  = '{1, 10, 0, 0, 0, 0, 0, 10, 1};
        vecs[7]  = '{0, 12, 0, 1, 0, 0, 0, 12, 2};
        vecs[8]  = '{0, 12, 1, 0, 0, 0, 0, 0,  0};
        vecs[9]  = '{0, 12, 0, 0, 0, 0, 0, 12, 1};
        vecs[10] = '{0, 12, 0, 0, 0, 0, 0, 12, 1};

        #2;
        check_zero("reset_hold");
        do_reset(5);
        check_zero("reset_state");

        // vector table
        foreach (vecs[k]) begin
            inc_v   = vecs[k].inc;
            count_v = W'(vecs[k].count);
            clear_v = vecs[k].clr;
            tick();
            chk($sformatf("vec%0d.alarm_step", k), int'(alarm_step), int'(vecs[k].e_step));
            chk($sformatf("vec%0d.alarm_limit", k), int'(alarm_limit), int'(vecs[k].e_limit));
            chk($sformatf("vec%0d.alarm_stall", k), int'(alarm_stall), int'(vecs[k].e_stall));
            chk($sformatf("vec%0d.wrap_pulse", k), int'(wrap_pulse), int'(vecs[k].e_wrap));
            chk($sformatf("vec%0d.max_seen", k), int'(max_seen), vecs[k].e_max);
            chk($sformatf("vec%0d.state", k), int'(state), vecs[k].e_state);
        end
        clear_v = 1'b0;

        // illegal jump 7 -> 9 while a step of 1 is expected
        do_reset(7);
        ctr(1'b1);
        count_v = 9;
        inc_v = 1'b0;
        tick();
        chk("jump.alarm_step", int'(alarm_step), 1);
        chk("jump.state", int'(state), 2);
        chk("jump.alarm_limit", int'(alarm_limit), 0);
        chk("jump.alarm_stall", int'(alarm_stall), 0);

        // legal wrap 1023 -> 0
        do_reset(1021);
        ctr(1'b1);
        ctr(1'b1);
        ctr(1'b1);
        chk("prewrap.alarm_limit", int'(alarm_limit), 1);
        chk("prewrap.wrap_pulse", int'(wrap_pulse), 0);
        ctr(1'b1);
        chk("wrap.wrap_pulse", int'(wrap_pulse), 1);
        chk("wrap.alarm_step", int'(alarm_step), 0);
        chk("wrap.alarm_limit", int'(alarm_limit), 1);
        ctr(1'b0);
        chk("postwrap.wrap_pulse", int'(wrap_pulse), 0);
        check_model("wrap");

        // stall: 16 idle cycles trip, 15 do not
        do_reset(3);
        ctr(1'b0);
        for (int k = 1; k <= SMAX; k++) begin
            ctr(1'b0);
            chk($sformatf("stall%0d.alarm_stall", k), int'(alarm_stall), (k >= SMAX) ? 1 : 0);
        end
        do_reset(3);
        ctr(1'b0);
        for (int k = 1; k <= SMAX + 4; k++) begin
            ctr(k == SMAX - 1);
            chk($sformatf("nostall%0d.alarm_stall", k), int'(alarm_stall), 0);
        end

        // clear beats an active limit condition, limit returns two cycles later
        do_reset(1003);
        ctr(1'b1);
        ctr(1'b1);
        ctr(1'b0);
        chk("preclr.alarm_limit", int'(alarm_limit), 1);
        clear_v = 1'b1;
        ctr(1'b0);
        clear_v = 1'b0;
        chk("clr.alarm_limit", int'(alarm_limit), 0);
        chk("clr.max_seen", int'(max_seen), 0);
        chk("clr.state", int'(state), 0);
        ctr(1'b0);
        chk("clr1.alarm_limit", int'(alarm_limit), 0);
        chk("clr1.state", int'(state), 1);
        ctr(1'b0);
        chk("clr2.alarm_limit", int'(alarm_limit), 1);
        chk("clr2.max_seen", int'(max_seen), 1005);

        // asynchronous reset in the middle of a tripped run
        do_reset(40);
        ctr(1'b1);
        count_v = 60;
        ctr(1'b1);
        chk("prerst.alarm_step", int'(alarm_step), 1);
        @(negedge clk);
        rst_n = 1'b0;
        hc.delete();
        hi.delete();
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        count_v = 500;
        ctr(1'b1);
        ctr(1'b0);
        chk("post_rst.alarm_step", int'(alarm_step), 0);
        check_model("post_rst");

        // randomized run against the reference model
        p = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                if ($urandom_range(0, 1) == 0) do_reset(int'($urandom_range(980, 1023)));
                else do_reset(int'($urandom_range(0, 1023)));
            end
            if (cyc % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: p = 0;
                    1: p = 10;
                    2: p = 50;
                    default: p = 95;
                endcase
            end
            if ($urandom_range(0, 99) < 3) count_v = W'($urandom);
            clear_v = ($urandom_range(0, 99) < 2);
            ctr($urandom_range(0, 99) < p);
            clear_v = 1'b0;
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Downstream checker for the up-counter stage. It consumes the counter's `out` value and its `in` increment strobe.
- Checks step legality, threshold crossing, wrap-around and increment starvation, cycle by cycle.
- Raises sticky alarms and keeps a running maximum for the bench and for formal properties.
- Sits between the counter and the system status logic.

Parameters:
- WIDTH, 10, width of the monitored count.
- LIMIT, 1000, threshold; count >= LIMIT raises alarm_limit. Must be < 2^WIDTH.
- STALL_MAX, 16, number of consecutive cycles with inc low that raises alarm_stall. Range 1..255.

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- rst_n  in  1  asynchronous active-low reset.
- inc  in  1  increment strobe, same signal that drives the counter's `in`.
- count  in  WIDTH  counter output.
- clear  in  1  synchronous clear of all sticky alarms and of max_seen.
- alarm_step  out  1  sticky: illegal count transition seen.
- alarm_limit  out  1  sticky: count reached LIMIT.
- alarm_stall  out  1  sticky: inc low for STALL_MAX consecutive cycles.
- wrap_pulse  out  1  one-cycle pulse on a legal wrap from 2^WIDTH-1 to 0.
- max_seen  out  WIDTH  largest count sampled since reset or clear.
- state  out  2  FSM state: 0 INIT, 1 RUN, 2 TRIP.

Behaviour:
- Reset, asynchronous, on rst_n low:
  - all alarms 0, wrap_pulse 0, max_seen 0, state INIT;
  - internal prev_count 0, inc_d 0, stall_cnt 0.
- Reset mid-operation clears everything immediately; no pending pulse survives.
- Timing model: the counter updates one cycle after inc. The expected step at cycle t is therefore inc_d, which is inc registered at t-1.
- INIT, the first cycle after reset release:
  - capture prev_count <= count and inc_d <= inc;
  - no checks, no alarms;
  - go to RUN.
- RUN, every cycle:
  - delta = (count - prev_count) mod 2^WIDTH, computed at WIDTH bits.
  - If delta != inc_d, set alarm_step and go to TRIP.
  - If delta == 1 and count == 0, assert wrap_pulse for this cycle only. A wrap is legal, not an alarm.
  - If count >= LIMIT (unsigned), set alarm_limit. State stays RUN.
  - If count > max_seen, update max_seen.
  - stall_cnt: cleared when inc=1, otherwise incremented, saturating at STALL_MAX. At STALL_MAX, set alarm_stall and hold stall_cnt.
  - Always update prev_count <= count and inc_d <= inc.
- TRIP:
  - alarm_step stays 1; step checks are suspended.
  - Limit, stall, max_seen and wrap tracking continue.
  - prev_count and inc_d keep updating.
- clear (synchronous, highest priority after reset):
  - alarms and max_seen cleared to 0, stall_cnt cleared;
  - state returns to INIT so the next cycle re-captures prev_count;
  - wrap_pulse 0 in that cycle;
  - if a condition that would raise an alarm is true in the clear cycle, clear wins. The alarm can reassert from the next evaluated cycle.
- Output latency:
  - alarms register on the edge after the offending sample; visible one cycle after the bad count appears;
  - wrap_pulse is registered the same way;
  - max_seen is registered.
- Simultaneous events: alarm_step, alarm_limit and alarm_stall may all set in the same cycle. Each is independent.

Optional Feature:
- Macro: COUNT_MONITOR_ASSERT_EN.
- Defined: compile immediate assertions for formal/BMC.
  - assert !alarm_step;
  - assert max_seen >= prev_count whenever state == RUN;
  - assert wrap_pulse implies state != INIT.
  - Use an internal initstate register, 1 after reset and 0 thereafter, to gate the assertions out of the first cycle.
- Not defined: no assertion logic and no initstate register. Functional outputs are identical either way.

Test Plan:
- Reset, then inc=1 for 5 cycles starting from count=5, following the counter model -> count reaches 10, no alarms, max_seen=10, state RUN.
- Force count to jump 7 -> 9 with inc_d=1 -> alarm_step=1 one cycle later, state TRIP, other alarms 0.
- Count 1022 -> 1023 -> 0 with inc=1 and WIDTH=10 -> wrap_pulse high exactly one cycle, alarm_step 0, alarm_limit already 1 since 1022 >= 1000.
- inc held 0 for 16 cycles with STALL_MAX=16 -> alarm_stall rises on the 16th cycle. A single inc=1 at cycle 15 -> no alarm.
- Assert clear while alarm_limit=1 and count=1005 -> alarms 0 and max_seen 0 that cycle, state INIT, then alarm_limit=1 again two cycles later.
- Drop rst_n mid-run with alarm_step=1 -> all outputs 0 and state INIT asynchronously. After release, no false alarm_step on the first sample.
